// File: rtl/maze_player_ctrl.sv
// Maze player controller: movement with hold-to-repeat, one-cycle map lookup,
// lives, seconds timer and game state in a single sequential block.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   dir[3:0]                held direction levels {up, down, left, right}
//   start_btn               one-cycle start pulse (IDLE/OVER/WON only)
//   tile_req, tile_x/y      lookup strobe and candidate position
//   tile_kind, tp_x/y       lookup result, valid the cycle after tile_req
//   pos_x/y                 player top-left corner
//   game_state              0 IDLE, 1 PLAY, 2 OVER, 3 WON
//   lives, seconds, moved   remaining lives, play time, step pulse
module maze_player_ctrl #(
    parameter int SCR_W         = 640,
    parameter int SCR_H         = 480,
    parameter int BLK           = 10,
    parameter int STEP          = 10,
    parameter int START_X       = 20,
    parameter int START_Y       = 20,
    parameter int LIVES         = 3,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int REPEAT_DLY    = 25_000_000,
    parameter int REPEAT_RATE   = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] dir,
    input  logic       start_btn,
    output logic       tile_req,
    output logic [9:0] tile_x,
    output logic [8:0] tile_y,
    input  logic [2:0] tile_kind,
    input  logic [9:0] tp_x,
    input  logic [8:0] tp_y,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic [1:0] game_state,
    output logic [2:0] lives,
    output logic [9:0] seconds,
    output logic       moved
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_LOOK = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;
    localparam logic [2:0] S_WON  = 3'd5;

    localparam logic [2:0] K_WALL = 3'd1;
    localparam logic [2:0] K_LAVA = 3'd2;
    localparam logic [2:0] K_GOAL = 3'd3;
    localparam logic [2:0] K_TELE = 3'd4;

    localparam int TW   = $clog2(TICKS_PER_SEC + 1);
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [9:0] X0 = 10'(START_X);
    localparam logic [8:0] Y0 = 9'(START_Y);

    // Two extra bits so the candidate is signed and never wraps.
    localparam logic signed [11:0] STEP_X = 12'(STEP);
    localparam logic signed [10:0] STEP_Y = 11'(STEP);
    localparam logic signed [11:0] MAX_X  = 12'(SCR_W - BLK);
    localparam logic signed [10:0] MAX_Y  = 11'(SCR_H - BLK);

    logic [2:0]    state_q, state_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [8:0]    pos_y_q, pos_y_d;
    logic [2:0]    lives_q, lives_d;
    logic [9:0]    sec_q, sec_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          req_q, req_d;
    logic [9:0]    tx_q, tx_d;
    logic [8:0]    ty_q, ty_d;
    logic          moved_q, moved_d;
    logic [3:0]    dprev_q;
    logic [3:0]    sel_q, sel_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rrate_q, rrate_d;

    logic [3:0]        sel;
    logic [RW-1:0]     rinc;
    logic              rep_fire;
    logic              step_req;
    logic signed [11:0] cx;
    logic signed [10:0] cy;
    logic              in_range;
    logic              in_play;

    // Highest-priority held direction, one-hot.
    always_comb begin
        sel = 4'b0000;
        if (dir[3])      sel = 4'b1000;
        else if (dir[2]) sel = 4'b0100;
        else if (dir[1]) sel = 4'b0010;
        else if (dir[0]) sel = 4'b0001;
    end

    // Repeat counter: restarts whenever the selection changes; fires after
    // REPEAT_DLY cycles, then every REPEAT_RATE cycles.
    always_comb begin
        rinc     = rcnt_q + 1'b1;
        rep_fire = 1'b0;
        rcnt_d   = rinc;
        rrate_d  = rrate_q;
        sel_d    = sel;
        if (sel == 4'b0000 || sel != sel_q) begin
            rcnt_d  = '0;
            rrate_d = 1'b0;
        end else if ((!rrate_q && rinc == RW'(REPEAT_DLY)) ||
                     ( rrate_q && rinc == RW'(REPEAT_RATE))) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
            rrate_d  = 1'b1;
        end
    end

    assign step_req = (|(sel & ~dprev_q)) | rep_fire;

    always_comb begin
        cx = $signed({2'b00, pos_x_q});
        cy = $signed({2'b00, pos_y_q});
        unique case (1'b1)
            sel[3]:  cy = cy - STEP_Y;
            sel[2]:  cy = cy + STEP_Y;
            sel[1]:  cx = cx - STEP_X;
            sel[0]:  cx = cx + STEP_X;
            default: ;
        endcase
        in_range = (cx >= 12'sd0) && (cx <= MAX_X) &&
                   (cy >= 11'sd0) && (cy <= MAX_Y);
    end

    assign in_play = (state_q == S_WAIT) || (state_q == S_LOOK) ||
                     (state_q == S_CHK);

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        lives_d = lives_q;
        sec_d   = sec_q;
        tick_d  = tick_q;
        req_d   = 1'b0;
        tx_d    = tx_q;
        ty_d    = ty_q;
        moved_d = 1'b0;

        if (in_play) begin
            if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
                tick_d = '0;
                if (sec_q < 10'd999) sec_d = sec_q + 10'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_OVER, S_WON: begin
                if (start_btn) begin
                    state_d = S_WAIT;
                    pos_x_d = X0;
                    pos_y_d = Y0;
                    lives_d = 3'(LIVES);
                    sec_d   = '0;
                    tick_d  = '0;
                end
            end
            S_WAIT: begin
                if (step_req && in_range) begin
                    req_d   = 1'b1;
                    tx_d    = cx[9:0];
                    ty_d    = cy[8:0];
                    state_d = S_LOOK;
                end
            end
            S_LOOK: state_d = S_CHK;
            S_CHK: begin
                state_d = S_WAIT;
                case (tile_kind)
                    K_WALL: ;
                    K_LAVA: begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = S_OVER;
                        end else begin
                            pos_x_d = X0;
                            pos_y_d = Y0;
                            moved_d = 1'b1;
                        end
                    end
                    K_GOAL: begin
                        pos_x_d = tx_q;
                        pos_y_d = ty_q;
                        moved_d = 1'b1;
                        state_d = S_WON;
                    end
                    K_TELE: begin
                        pos_x_d = tp_x;
                        pos_y_d = tp_y;
                        moved_d = 1'b1;
                    end
                    default: begin
                        pos_x_d = tx_q;
                        pos_y_d = ty_q;
                        moved_d = 1'b1;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pos_x_q <= X0;
            pos_y_q <= Y0;
            lives_q <= 3'(LIVES);
            sec_q   <= '0;
            tick_q  <= '0;
            req_q   <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            moved_q <= 1'b0;
            dprev_q <= '0;
            sel_q   <= '0;
            rcnt_q  <= '0;
            rrate_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            lives_q <= lives_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            req_q   <= req_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            moved_q <= moved_d;
            dprev_q <= dir;
            sel_q   <= sel_d;
            rcnt_q  <= rcnt_d;
            rrate_q <= rrate_d;
        end
    end

    always_comb begin
        game_state = 2'd0;
        if (in_play)                game_state = 2'd1;
        else if (state_q == S_OVER) game_state = 2'd2;
        else if (state_q == S_WON)  game_state = 2'd3;
    end

    assign tile_req = req_q;
    assign tile_x   = tx_q;
    assign tile_y   = ty_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign lives    = lives_q;
    assign seconds  = sec_q;
    assign moved    = moved_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl with small timing parameters
// (LIVES=2, TICKS_PER_SEC=4, REPEAT_DLY=20, REPEAT_RATE=8).
module tb_maze_player_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] dir;
    logic       start_btn;
    logic       tile_req;
    logic [9:0] tile_x;
    logic [8:0] tile_y;
    logic [2:0] tile_kind;
    logic [9:0] tp_x;
    logic [8:0] tp_y;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic [1:0] game_state;
    logic [2:0] lives;
    logic [9:0] seconds;
    logic       moved;

    int checks = 0;
    int errors = 0;
    int nreq;
    int nmov;

    maze_player_ctrl #(
        .LIVES(2),
        .TICKS_PER_SEC(4),
        .REPEAT_DLY(20),
        .REPEAT_RATE(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .dir(dir),
        .start_btn(start_btn),
        .tile_req(tile_req),
        .tile_x(tile_x),
        .tile_y(tile_y),
        .tile_kind(tile_kind),
        .tp_x(tp_x),
        .tp_y(tp_y),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .game_state(game_state),
        .lives(lives),
        .seconds(seconds),
        .moved(moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse();
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
    endtask

    // Hold d for one cycle, then watch the three cycles of a step.
    task automatic tap(input logic [3:0] d, output int r, output int m);
        r = 0;
        m = 0;
        dir = d;
        for (int i = 0; i < 3; i++) begin
            step(1);
            dir = 4'b0000;
            if (tile_req) r++;
            if (moved) m++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        dir       = 4'b0000;
        start_btn = 1'b0;
        tile_kind = 3'd0;
        tp_x      = 10'd0;
        tp_y      = 9'd0;
        step(3);
        chk("rst_state", game_state, 0);
        chk("rst_pos_x", pos_x, 20);
        chk("rst_pos_y", pos_y, 20);
        chk("rst_lives", lives, 2);
        chk("rst_sec", seconds, 0);
        chk("rst_req", tile_req, 0);
        chk("rst_moved", moved, 0);
        chk("rst_tile_x", tile_x, 0);
        reset_n = 1'b1;
        step(2);

        tap(4'b0001, nreq, nmov);
        chk("idle_dir_req", nreq, 0);

        start_pulse();
        chk("start_state", game_state, 1);

        // Single right tap on a free tile, cycle by cycle.
        dir = 4'b0001;
        step(1);
        chk("tap_req", tile_req, 1);
        chk("tap_tile_x", tile_x, 30);
        chk("tap_tile_y", tile_y, 20);
        dir = 4'b0000;
        step(1);
        chk("tap_req_drop", tile_req, 0);
        step(1);
        chk("tap_pos_x", pos_x, 30);
        chk("tap_moved", moved, 1);
        step(1);
        chk("tap_moved_drop", moved, 0);

        // Teleport to (20,100).
        tile_kind = 3'd4;
        tp_x = 10'd20;
        tp_y = 9'd100;
        tap(4'b0001, nreq, nmov);
        chk("tp1_pos_x", pos_x, 20);
        chk("tp1_pos_y", pos_y, 100);

        // Hold up for DLY + 2*RATE = 36 cycles: edge + two repeats.
        tile_kind = 3'd0;
        nmov = 0;
        dir = 4'b1000;
        for (int i = 0; i < 36; i++) begin
            step(1);
            if (moved) nmov++;
        end
        dir = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (moved) nmov++;
        end
        chk("hold_steps", nmov, 3);
        chk("hold_pos_y", pos_y, 70);

        // Left edge: step dropped, no lookup.
        tile_kind = 3'd4;
        tp_x = 10'd0;
        tp_y = 9'd50;
        tap(4'b0001, nreq, nmov);
        chk("tp2_pos_x", pos_x, 0);
        tile_kind = 3'd0;
        tap(4'b0010, nreq, nmov);
        chk("edge_req", nreq, 0);
        chk("edge_pos_x", pos_x, 0);

        // Wall below.
        tile_kind = 3'd1;
        tap(4'b0100, nreq, nmov);
        chk("wall_req", nreq, 1);
        chk("wall_tile_y", tile_y, 60);
        chk("wall_moved", nmov, 0);
        chk("wall_pos_y", pos_y, 50);

        // Teleport to (300,200).
        tile_kind = 3'd4;
        tp_x = 10'd300;
        tp_y = 9'd200;
        tap(4'b0001, nreq, nmov);
        chk("tp3_pos_x", pos_x, 300);
        chk("tp3_pos_y", pos_y, 200);
        chk("tp3_moved", nmov, 1);

        // Lava twice.
        tile_kind = 3'd2;
        tap(4'b0001, nreq, nmov);
        chk("lava1_lives", lives, 1);
        chk("lava1_pos_x", pos_x, 20);
        chk("lava1_pos_y", pos_y, 20);
        chk("lava1_moved", nmov, 1);
        tap(4'b0001, nreq, nmov);
        chk("lava2_lives", lives, 0);
        chk("lava2_state", game_state, 2);
        chk("lava2_moved", nmov, 0);
        chk("lava2_pos_x", pos_x, 20);
        tap(4'b0001, nreq, nmov);
        chk("over_dir_req", nreq, 0);

        // Restart; timer counts from zero, start in PLAY is ignored.
        tile_kind = 3'd0;
        start_pulse();
        chk("restart_state", game_state, 1);
        chk("restart_lives", lives, 2);
        chk("restart_sec", seconds, 0);
        step(8);
        start_pulse();
        chk("play_start_state", game_state, 1);
        chk("play_start_sec", seconds, 2);

        // Goal.
        tile_kind = 3'd3;
        tap(4'b0001, nreq, nmov);
        chk("goal_state", game_state, 3);
        chk("goal_pos_x", pos_x, 30);
        tile_kind = 3'd0;
        tap(4'b0001, nreq, nmov);
        chk("won_dir_req", nreq, 0);
        chk("won_pos_x", pos_x, 30);

        // Seconds saturation.
        start_pulse();
        step(4100);
        chk("sec_sat", seconds, 999);
        chk("sat_state", game_state, 1);

        // Asynchronous reset in the middle of a lookup.
        dir = 4'b0001;
        step(1);
        chk("pre_rst_req", tile_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", tile_req, 0);
        chk("arst_state", game_state, 0);
        chk("arst_pos_x", pos_x, 20);
        chk("arst_pos_y", pos_y, 20);
        chk("arst_sec", seconds, 0);
        chk("arst_lives", lives, 2);
        chk("arst_tile_x", tile_x, 0);
        chk("arst_moved", moved, 0);
        dir = 4'b0000;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
